// File: rtl/imem_program_loader_if.sv
// Request and instruction-memory write bus of the program loader.
// The requester (bench or host) uses the master view, the loader uses the slave view.
interface imem_program_loader_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_kind;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [4:0]        req_rd;
    logic [15:0]       req_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output req_valid, req_kind, req_rs, req_rt, req_rd, req_imm,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  req_valid, req_kind, req_rs, req_rt, req_rd, req_imm,
        output req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_program_loader.sv
// Instruction encoder/loader: assembles MIPS ADD/SUB/LW/SW/BEQ words from
// field-level requests and writes them sequentially into instruction memory.
// busy holds the processor pipeline in reset while a program is loaded.
module imem_program_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  finish,
    imem_program_loader_if.slave  bus,
    output logic [ADDR_W:0]       count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    // Kinds 0..4 are encodable; 5..7 are rejected.
    function automatic logic kind_legal(input logic [2:0] kind);
        return (kind <= 3'd4);
    endfunction

    // Field-level request to 32-bit MIPS word.
    function automatic logic [31:0] encode(input logic [2:0]  kind,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [4:0]  rd,
                                           input logic [15:0] imm);
        logic [31:0] word;
        case (kind)
            3'd0:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            3'd1:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
            3'd2:    word = {6'b100011, rs, rt, imm};
            3'd3:    word = {6'b101011, rs, rt, imm};
            3'd4:    word = {6'b000100, rs, rt, imm};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] ptr_r, ptr_s;
    logic [ADDR_W:0]   count_r, count_s;
    logic              pend_r, pend_s;
    logic              ready_r, ready_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [31:0]       wdata_r, wdata_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic [ADDR_W:0]   count_inc_s;

    assign count_inc_s = count_r + {{ADDR_W{1'b0}}, 1'b1};

    // Next-state and next-output computation; every output is the registered
    // image of these values so nothing combinational reaches a port.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        count_s = count_r;
        pend_s  = pend_r;
        ready_s = 1'b0;
        we_s    = 1'b0;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        busy_s  = 1'b0;
        done_s  = done_r;
        err_s   = err_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = LOAD;
                    ptr_s   = BASE_PTR;
                    count_s = {(ADDR_W+1){1'b0}};
                    pend_s  = 1'b0;
                    err_s   = 1'b0;
                    done_s  = 1'b0;
                    ready_s = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            LOAD: begin
                busy_s = 1'b1;
                if (bus.req_valid && ready_r) begin
                    if (kind_legal(bus.req_kind)) begin
                        state_s = WRITE;
                        we_s    = 1'b1;
                        addr_s  = ptr_r;
                        wdata_s = encode(bus.req_kind, bus.req_rs, bus.req_rt,
                                         bus.req_rd, bus.req_imm);
                        pend_s  = finish;
                    end else if (finish) begin
                        // Rejected request leaves nothing in flight, so finish can end now.
                        err_s   = 1'b1;
                        state_s = DONE;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                    end else begin
                        err_s   = 1'b1;
                        ready_s = 1'b1;
                    end
                end else if (finish) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    ready_s = 1'b1;
                end
            end
            WRITE: begin
                ptr_s   = ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                count_s = count_inc_s;
                if ((count_inc_s == CAPACITY) || pend_r || finish) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                    pend_s  = 1'b0;
                end else begin
                    state_s = LOAD;
                    ready_s = 1'b1;
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= BASE_PTR;
            count_r <= {(ADDR_W+1){1'b0}};
            pend_r  <= 1'b0;
            ready_r <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= 32'h0000_0000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            count_r <= count_s;
            pend_r  <= pend_s;
            ready_r <= ready_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign bus.req_ready  = ready_r;
    assign bus.imem_we    = we_r;
    assign bus.imem_addr  = addr_r;
    assign bus.imem_wdata = wdata_r;
    assign count          = count_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: expected writes are queued when a
// request is driven and popped by a monitor whenever imem_we is seen.
module tb_imem_program_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic       finish;
    logic [6:0] count;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    logic [37:0] sb[$];
    logic [5:0]  exp_ptr;

    imem_program_loader_if #(.ADDR_W(6)) bus ();

    imem_program_loader #(.ADDR_W(6), .BASE_ADDR(0)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .finish (finish),
        .bus    (bus),
        .count  (count),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [37:0] e;
        if (bus.imem_we === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write observed addr=%0h data=%0h expected none",
                       bus.imem_addr, bus.imem_wdata);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("write_addr", {34'd0, bus.imem_addr}, {34'd0, e[37:32]});
                chk("write_data", {8'd0, bus.imem_wdata}, {8'd0, e[31:0]});
            end
        end
    end

    function automatic logic [31:0] add_word(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_ptr = 6'd0;
    endtask

    task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm,
                        input logic [31:0] word, input logic fin);
        int n;
        n = 0;
        bus.req_kind  = k;
        bus.req_rs    = rs;
        bus.req_rt    = rt;
        bus.req_rd    = rd;
        bus.req_imm   = imm;
        bus.req_valid = 1'b1;
        finish        = fin;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", {39'd0, (n < 20)}, 40'd1);
        if (k <= 3'd4) sb.push_back({exp_ptr, word});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        finish        = 1'b0;
        if (k <= 3'd4) begin
            chk("we_latency", {39'd0, bus.imem_we}, 40'd1);
            exp_ptr = exp_ptr + 6'd1;
        end else begin
            chk("illegal_no_write", {39'd0, bus.imem_we}, 40'd0);
            chk("illegal_err", {39'd0, err}, 40'd1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0;
        bus.req_valid = 1'b0; bus.req_kind = 3'd0; bus.req_rs = 5'd0;
        bus.req_rt = 5'd0; bus.req_rd = 5'd0; bus.req_imm = 16'd0;
        exp_ptr = 6'd0;
        #12;
        chk("rst_we", {39'd0, bus.imem_we}, 40'd0);
        chk("rst_ready", {39'd0, bus.req_ready}, 40'd0);
        chk("rst_busy", {39'd0, busy}, 40'd0);
        chk("rst_done", {39'd0, done}, 40'd0);
        chk("rst_err", {39'd0, err}, 40'd0);
        chk("rst_count", {33'd0, count}, 40'd0);
        @(negedge clk); rst = 1'b0;

        // Single ADD
        do_start();
        chk("start_busy", {39'd0, busy}, 40'd1);
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'd0, 32'h0022_1820, 1'b0);
        @(posedge clk); #1;
        chk("count_after_add", {33'd0, count}, 40'd1);
        finish = 1'b1; @(posedge clk); #1; finish = 1'b0;
        chk("finish_done", {39'd0, done}, 40'd1);
        chk("finish_busy", {39'd0, busy}, 40'd0);

        // All kinds, then illegal kind, then ADD lands at the next address
        do_start();
        chk("restart_done_clr", {39'd0, done}, 40'd0);
        send(3'd1, 5'd1, 5'd2, 5'd3, 16'd0,    32'h0022_1822, 1'b0);
        send(3'd2, 5'd0, 5'd8, 5'd0, 16'd4,    32'h8C08_0004, 1'b0);
        send(3'd3, 5'd0, 5'd8, 5'd0, 16'd4,    32'hAC08_0004, 1'b0);
        send(3'd4, 5'd1, 5'd2, 5'd0, 16'hFFFF, 32'h1022_FFFF, 1'b0);
        send(3'd5, 5'd1, 5'd2, 5'd3, 16'd0,    32'h0000_0000, 1'b0);
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'd0,    32'h0022_1820, 1'b0);
        @(posedge clk); #1;
        finish = 1'b1; @(posedge clk); #1; finish = 1'b0;
        chk("count_mixed", {33'd0, count}, 40'd5);
        chk("err_sticky", {39'd0, err}, 40'd1);

        // finish together with a request
        do_start();
        chk("start_err_clr", {39'd0, err}, 40'd0);
        send(3'd1, 5'd4, 5'd5, 5'd6, 16'd0, 32'h0085_3022, 1'b1);
        @(posedge clk); #1;
        chk("fin_hs_done", {39'd0, done}, 40'd1);
        chk("fin_hs_busy", {39'd0, busy}, 40'd0);
        chk("fin_hs_count", {33'd0, count}, 40'd1);

        // Fill the whole memory
        do_start();
        for (int i = 0; i < 64; i++) begin
            send(3'd0, 5'(i), 5'(i + 3), 5'(63 - i), 16'd0,
                 add_word(5'(i), 5'(i + 3), 5'(63 - i)), 1'b0);
        end
        @(posedge clk); #1;
        chk("full_done", {39'd0, done}, 40'd1);
        chk("full_count", {33'd0, count}, 40'd64);
        chk("full_ready", {39'd0, bus.req_ready}, 40'd0);
        bus.req_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("full_count_hold", {33'd0, count}, 40'd64);

        // Reset in the middle of a write
        do_start();
        bus.req_kind = 3'd0; bus.req_rs = 5'd7; bus.req_rt = 5'd7; bus.req_rd = 5'd7;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("pre_rst_we", {39'd0, bus.imem_we}, 40'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", {39'd0, bus.imem_we}, 40'd0);
        chk("mid_rst_busy", {39'd0, busy}, 40'd0);
        chk("mid_rst_done", {39'd0, done}, 40'd0);
        chk("mid_rst_count", {33'd0, count}, 40'd0);
        chk("mid_rst_err", {39'd0, err}, 40'd0);
        @(negedge clk); rst = 1'b0;
        do_start();
        send(3'd2, 5'd3, 5'd9, 5'd0, 16'h0010, 32'h8C69_0010, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", {8'd0, 32'(sb.size())}, 40'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
